// File: rtl/rat_checkpoint_ctrl.sv
// Checkpoint scheduler for the RAT shadow pages: allocates one page per branch,
// pulses save/restore to the RAT, and reclaims wrong-path pages on a mispredict.
module rat_checkpoint_ctrl #(
  parameter int NUM_PAGES = 8,
  parameter int TAG_W     = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 alloc_req_i,
  output logic [TAG_W-1:0]     alloc_tag_o,
  output logic                 stall_o,
  input  logic                 resolve_valid_i,
  input  logic [TAG_W-1:0]     resolve_tag_i,
  input  logic                 mispredict_i,
  output logic                 save_state_o,
  output logic [TAG_W-1:0]     save_page_o,
  output logic                 restore_state_o,
  output logic [TAG_W-1:0]     restore_page_o,
  output logic                 flush_o,
  output logic [NUM_PAGES-1:0] busy_mask_o,
  output logic [TAG_W:0]       count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e               state_q;
  logic [TAG_W-1:0]     head_q, head_d;
  logic [TAG_W-1:0]     tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic [NUM_PAGES-1:0] busy_q, busy_d;
  logic [NUM_PAGES-1:0] done_q, done_d;
  logic                 save_state_q;
  logic [TAG_W-1:0]     save_page_q;
  logic                 restore_state_q;
  logic [TAG_W-1:0]     restore_page_q;
  logic                 flush_q;

  logic                 mp_hit;
  logic                 ok_hit;
  logic                 full;
  logic                 stall;
  logic                 alloc_fire;
  logic                 retire_en;
  logic [TAG_W-1:0]     age_t;
  logic [TAG_W:0]       span;
  logic [NUM_PAGES-1:0] kill;

  assign mp_hit     = resolve_valid_i & mispredict_i & busy_q[resolve_tag_i] & (state_q == IDLE);
  assign ok_hit     = resolve_valid_i & ~mispredict_i & busy_q[resolve_tag_i];
  assign full       = (count_q == (TAG_W+1)'(NUM_PAGES));
  assign stall      = full | (state_q != IDLE) | save_state_q | mp_hit;
  assign alloc_fire = alloc_req_i & ~stall;
  // A mispredict on the head page frees everything, so the head must not also retire.
  assign retire_en  = busy_q[head_q] & done_q[head_q] & ~(mp_hit & (resolve_tag_i == head_q));
  assign age_t      = resolve_tag_i - head_q;

  always_comb begin
    span = {1'b0, resolve_tag_i} - {1'b0, head_q};
    if (span[TAG_W]) begin
      span = span + (TAG_W+1)'(NUM_PAGES);
    end
  end

  // Pages at or younger than the mispredicted one (by age from head) are wrong-path.
  generate
    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_kill
      logic [TAG_W-1:0] age;
      assign age      = TAG_W'(gi) - head_q;
      assign kill[gi] = mp_hit & (age >= age_t);
    end
  endgenerate

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (ok_hit) begin
      done_d[resolve_tag_i] = 1'b1;
    end
    if (retire_en) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (mp_hit) begin
      busy_d  = busy_d & ~kill;
      done_d  = done_d & ~kill;
      tail_d  = resolve_tag_i;
      count_d = span - (TAG_W+1)'(retire_en);
    end else begin
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + 1'b1;
      end
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_en);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      done_q          <= '0;
      save_state_q    <= 1'b0;
      save_page_q     <= '0;
      restore_state_q <= 1'b0;
      restore_page_q  <= '0;
      flush_q         <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      save_state_q    <= alloc_fire;
      if (alloc_fire) begin
        save_page_q <= tail_q;
      end
      restore_state_q <= 1'b0;
      flush_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mp_hit) begin
            state_q         <= RESTORE;
            restore_state_q <= 1'b1;
            restore_page_q  <= resolve_tag_i;
          end
        end
        RESTORE: begin
          state_q <= RECOVER;
          flush_q <= 1'b1;
        end
        RECOVER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alloc_tag_o     = tail_q;
  assign stall_o         = stall;
  assign save_state_o    = save_state_q;
  assign save_page_o     = save_page_q;
  assign restore_state_o = restore_state_q;
  assign restore_page_o  = restore_page_q;
  assign flush_o         = flush_q;
  assign busy_mask_o     = busy_q;
  assign count_o         = count_q;

endmodule

// File: tb/tb_rat_checkpoint_ctrl.sv
// Scoreboard bench for rat_checkpoint_ctrl: a queue-of-branches model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_rat_checkpoint_ctrl;

  localparam int NP = 8;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       alloc_req_i;
  logic [2:0] alloc_tag_o;
  logic       stall_o;
  logic       resolve_valid_i;
  logic [2:0] resolve_tag_i;
  logic       mispredict_i;
  logic       save_state_o;
  logic [2:0] save_page_o;
  logic       restore_state_o;
  logic [2:0] restore_page_o;
  logic       flush_o;
  logic [7:0] busy_mask_o;
  logic [3:0] count_o;

  rat_checkpoint_ctrl #(.NUM_PAGES(NP), .TAG_W(3)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .alloc_req_i    (alloc_req_i),
    .alloc_tag_o    (alloc_tag_o),
    .stall_o        (stall_o),
    .resolve_valid_i(resolve_valid_i),
    .resolve_tag_i  (resolve_tag_i),
    .mispredict_i   (mispredict_i),
    .save_state_o   (save_state_o),
    .save_page_o    (save_page_o),
    .restore_state_o(restore_state_o),
    .restore_page_o (restore_page_o),
    .flush_o        (flush_o),
    .busy_mask_o    (busy_mask_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int count;
    int busy;
    bit stall;
    bit fire;
    int tag;
    bit save;
    int spage;
    bit rest;
    int rpage;
    bit flush;
  } exp_t;

  exp_t sb[$];

  // Model: in-flight branches oldest-first, each with its page tag and resolved flag.
  int m_tag[$];
  bit m_done[$];
  int m_tail;
  int m_phase;   // 0 normal, 1 restoring, 2 flushing
  bit m_save;
  int m_save_pg;
  int m_rpage;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_tag.delete();
    m_done.delete();
    m_tail    = 0;
    m_phase   = 0;
    m_save    = 1'b0;
    m_save_pg = 0;
    m_rpage   = 0;
  endtask

  task automatic step(input bit areq, input bit rv, input int rtag, input bit mp);
    exp_t e;
    int   j;
    bit   hit;
    @(posedge clk_i);
    #1;
    alloc_req_i     = areq;
    resolve_valid_i = rv;
    resolve_tag_i   = rtag[2:0];
    mispredict_i    = mp;
    j = -1;
    for (int k = 0; k < m_tag.size(); k++) if (m_tag[k] == rtag) j = k;
    hit     = (m_phase == 0) && rv && mp && (j >= 0);
    e.count = m_tag.size();
    e.busy  = 0;
    for (int k = 0; k < m_tag.size(); k++) e.busy = e.busy | (1 << m_tag[k]);
    e.stall = (m_tag.size() == NP) || (m_phase != 0) || m_save || hit;
    e.fire  = areq && !e.stall;
    e.tag   = m_tail;
    e.save  = m_save;
    e.spage = m_save_pg;
    e.rest  = (m_phase == 1);
    e.rpage = m_rpage;
    e.flush = (m_phase == 2);
    sb.push_back(e);

    m_save = e.fire;
    if (e.fire) m_save_pg = m_tail;
    if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2) m_phase = 0;
    else if (hit) begin
      m_phase = 1;
      m_rpage = rtag;
    end

    if (hit) begin
      while (m_tag.size() > j) begin
        void'(m_tag.pop_back());
        void'(m_done.pop_back());
      end
      if (j > 0 && m_done[0]) begin
        void'(m_tag.pop_front());
        void'(m_done.pop_front());
      end
      m_tail = rtag;
    end else begin
      if (m_tag.size() > 0 && m_done[0]) begin
        void'(m_tag.pop_front());
        void'(m_done.pop_front());
      end
      if (rv && !mp) begin
        for (int k = 0; k < m_tag.size(); k++) if (m_tag[k] == rtag) m_done[k] = 1'b1;
      end
      if (e.fire) begin
        m_tag.push_back(m_tail);
        m_done.push_back(1'b0);
        m_tail = (m_tail + 1) % NP;
      end
    end
  endtask

  exp_t me;
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("count", int'(count_o), me.count);
      chk("busy_mask", int'(busy_mask_o), me.busy);
      chk("stall", int'(stall_o), int'(me.stall));
      chk("save_state", int'(save_state_o), int'(me.save));
      chk("restore_state", int'(restore_state_o), int'(me.rest));
      chk("flush", int'(flush_o), int'(me.flush));
      if (me.save) chk("save_page", int'(save_page_o), me.spage);
      if (me.rest) chk("restore_page", int'(restore_page_o), me.rpage);
      if (me.fire) begin
        chk("alloc_tag", int'(alloc_tag_o), me.tag);
        $display("alloc tag=%0d count=%0d", alloc_tag_o, count_o);
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_count"}, int'(count_o), 0);
    chk({nm, "_busy"}, int'(busy_mask_o), 0);
    chk({nm, "_save"}, int'(save_state_o), 0);
    chk({nm, "_restore"}, int'(restore_state_o), 0);
    chk({nm, "_flush"}, int'(flush_o), 0);
    chk({nm, "_rpage"}, int'(restore_page_o), 0);
    chk({nm, "_tag"}, int'(alloc_tag_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rt;
    bit rv;
    int rv_pct;
    reset_i         = 1'b1;
    alloc_req_i     = 1'b0;
    resolve_valid_i = 1'b0;
    resolve_tag_i   = '0;
    mispredict_i    = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    chk("reset_stall", int'(stall_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Allocs every other cycle
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk_i);
    chk("t1_count", int'(count_o), 3);
    chk("t1_busy", int'(busy_mask_o), 8'h07);

    // Mispredict in the middle of five pages
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 1, 2, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk_i);
    chk("t3_busy", int'(busy_mask_o), 8'h03);
    chk("t3_count", int'(count_o), 2);

    // Out-of-order resolves drain the buffer
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    @(negedge clk_i);
    chk("t4_count", int'(count_o), 0);

    // Fill all eight pages, then free one and wrap
    for (int i = 0; i < NP; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    @(negedge clk_i);
    chk("t2_count", int'(count_o), 8);
    chk("t2_busy", int'(busy_mask_o), 8'hFF);
    chk("t2_stall", int'(stall_o), 1);
    step(0, 1, m_tag[0], 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk_i);
    chk("t2_count7", int'(count_o), 7);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int r = 0; r < 6; r++) begin
      rv_pct = (r % 2 == 0) ? 10 : 45;
      for (int i = 0; i < 500; i++) begin
        rv = ($urandom_range(0, 99) < rv_pct);
        if (m_tag.size() > 0 && $urandom_range(0, 3) != 0)
          rt = m_tag[$urandom_range(0, m_tag.size() - 1)];
        else
          rt = $urandom_range(0, NP - 1);
        step($urandom_range(0, 99) < 60, rv, rt, rv && ($urandom_range(0, 99) < 10));
      end
    end
    step(0, 0, 0, 0);

    // Reset landing in RESTORE
    @(negedge clk_i);
    reset_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 1);
    @(posedge clk_i);
    #1;
    chk("t6_restore_pre", int'(restore_state_o), 1);
    chk("t6_rpage_pre", int'(restore_page_o), 0);
    reset_i = 1'b1;
    #1;
    check_zero("t6");
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    alloc_req_i     = 1'b0;
    resolve_valid_i = 1'b0;
    mispredict_i    = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk_i);
    chk("t6_after_count", int'(count_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
